wb_arbiter2: RTL and testbench
==============================

WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter AWIDTH, default 32: byte-address width carried on every bus.
REQ-002 SHALL have parameter DWIDTH, default 32: data width; sel width is DWIDTH/8.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in0, if_wb.slave, AWIDTH/DWIDTH: requester 0, pipelined Wishbone (adr, dat, sel, we, cyc, stb in; dat, ack, stall out).
REQ-006 SHALL have port in1, if_wb.slave, AWIDTH/DWIDTH: requester 1, same signal set as in0.
REQ-007 SHALL have port outbus, if_wb.master, AWIDTH/DWIDTH: shared memory-side bus, for example the port that feeds a cache's fill/flush path.
REQ-008 SHALL have port grant, output, 2: one-hot owner, bit0 = in0 and bit1 = in1; 2'b00 means no owner.

Function
REQ-009 SHALL implement a registered FSM with states S_IDLE, S_GRANT0, S_GRANT1 and S_RELEASE.
REQ-010 In S_IDLE with only inN.cyc high, SHALL enter S_GRANTN on the next edge.
REQ-011 In S_IDLE with both cyc high, SHALL grant the requester not in register last; last resets to 1, so in0 wins the first tie.
REQ-012 On entering S_GRANTN, SHALL set last to N.
REQ-013 In S_GRANTN, SHALL pass inN adr, dat, sel, we, cyc and stb combinationally to outbus.
REQ-014 In S_GRANTN, SHALL pass outbus dat, ack and stall combinationally to inN, with zero added latency.
REQ-015 A non-owner SHALL see stall=1, ack=0 and dat=0.
REQ-016 The grant SHALL be held for the owner's entire cyc assertion, including cycles with cyc=1 and stb=0 (burst tails awaiting acks).
REQ-017 Outstanding counter, 4 bits: SHALL increment on outbus.stb & ~outbus.stall and decrement on outbus.ack; with both in one cycle it SHALL stay unchanged.
REQ-018 The counter SHALL saturate at 15 (no increment) and floor at 0 (no decrement).
REQ-019 In S_GRANTN, when inN.cyc=0, SHALL go to S_RELEASE and clear the outstanding counter.
REQ-020 Any outbus.ack arriving after cyc drops SHALL be discarded and not forwarded to either requester.
REQ-021 S_RELEASE SHALL last exactly 1 cycle with outbus.cyc=0, then return to S_IDLE; this guarantees a cyc-low gap between owners.
REQ-022 In S_IDLE and S_RELEASE, outbus cyc, stb and we SHALL be 0, adr, dat and sel SHALL be 0, and both requesters SHALL be stalled.
REQ-023 Arbitration latency SHALL be 1 cycle from cyc rise in S_IDLE to first forwarded stb.
REQ-024 Worst-case handover SHALL be 2 cycles after owner cyc falls (S_RELEASE, S_IDLE), then grant.
REQ-025 A non-owner asserting cyc/stb SHALL be held by stall and SHALL receive no ack; the arbiter SHALL NOT buffer or drop its request.
REQ-026 grant SHALL equal 2'b01 in S_GRANT0, 2'b10 in S_GRANT1, and 2'b00 otherwise.

Reset
REQ-027 With rst_i high at a clock edge, SHALL set state=S_IDLE, last=1 and outstanding=0.
REQ-028 The reset values of REQ-027 SHALL take effect next cycle regardless of the current state, including mid-burst.
REQ-029 After reset, outbus cyc/stb/we/adr/dat/sel SHALL be 0, grant SHALL be 2'b00, both stalls SHALL be 1, and both acks SHALL be 0.
REQ-030 Reset mid-burst SHALL deassert outbus.cyc in the cycle after the reset edge; acks that follow SHALL be ignored.

Verification
REQ-031 Single requester: in0 issues a 4-beat read at 0x100/104/108/10C against a 1-cycle-ack slave returning 0xA0..A3 -> stb forwarded 1 cycle after cyc, in0 gets 4 acks with 0xA0..A3, grant=01 throughout, and in1 sees stall=1.
REQ-032 Tie after reset: in0 and in1 raise cyc in the same cycle -> grant=01 first; after in0 drops cyc: 1 S_RELEASE cycle, 1 S_IDLE cycle, then grant=10.
REQ-033 Round-robin: both requesters hold cyc continuously and release after each 4-beat write -> grants alternate 01,10,01,10 with no requester granted twice in a row.
REQ-034 Slave stall: slave stalls 3 cycles on beat 2 of an in1 write burst -> in1.stall mirrors outbus.stall, adr/dat hold, all 4 beats are acked, and the outstanding count returns to 0.
REQ-035 Late ack: owner drops cyc with 1 beat outstanding and the slave acks the following cycle -> the ack is not seen on in0 or in1, and outbus.cyc=0 in that cycle.
REQ-036 Reset mid-burst: rst_i pulses during in0 beat 2 of 4 -> outbus.cyc=0 next cycle, grant=00, and after release in0 re-arbitrates and wins (last=1).

Source files
------------

// File: rtl/wb_arbiter2_if.sv
// Pipelined Wishbone bundle: adr/dat_w/sel/we/cyc/stb from the master side,
// dat_r/ack/stall back from the slave side; sel is one bit per data byte.
interface if_wb #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) ();
    logic [AWIDTH-1:0]   adr;
    logic [DWIDTH-1:0]   dat_w;
    logic [DWIDTH-1:0]   dat_r;
    logic [DWIDTH/8-1:0] sel;
    logic                we;
    logic                cyc;
    logic                stb;
    logic                ack;
    logic                stall;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack, stall
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, stall
    );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-requester pipelined Wishbone arbiter, round-robin on ties.
// Ports: clk_i, rst_i (sync, active-high), in0/in1 (requesters),
// outbus (shared memory side), grant (one-hot owner, 00 = none).
module wb_arbiter2 #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_wb.slave        in0,
    if_wb.slave        in1,
    if_wb.master       outbus,
    output logic [1:0] grant
);
    localparam int SWIDTH = DWIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT0,
        S_GRANT1,
        S_RELEASE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       last;
    logic       last_nx;
    logic [3:0] outstanding;
    logic [3:0] outstanding_nx;
    logic       owner_cyc;
    logic       beat_issued;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            last        <= 1'b1;
            outstanding <= 4'd0;
        end else begin
            state       <= state_nx;
            last        <= last_nx;
            outstanding <= outstanding_nx;
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        unique case (state)
            S_IDLE: begin
                // On a tie the requester that did not own the bus last wins
                if (in0.cyc && (!in1.cyc || last)) begin
                    state_nx = S_GRANT0;
                    last_nx  = 1'b0;
                end else if (in1.cyc) begin
                    state_nx = S_GRANT1;
                    last_nx  = 1'b1;
                end
            end
            S_GRANT0: if (!in0.cyc) state_nx = S_RELEASE;
            S_GRANT1: if (!in1.cyc) state_nx = S_RELEASE;
            S_RELEASE: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Outstanding beats of the current owner; dropped cyc abandons them
    assign owner_cyc = (state == S_GRANT0 && in0.cyc)
                     || (state == S_GRANT1 && in1.cyc);
    assign beat_issued = outbus.stb && !outbus.stall;

    always_comb begin
        outstanding_nx = outstanding;
        if (!owner_cyc) begin
            outstanding_nx = 4'd0;
        end else if (beat_issued && !outbus.ack) begin
            if (outstanding != 4'd15) outstanding_nx = outstanding + 4'd1;
        end else if (outbus.ack && !beat_issued) begin
            if (outstanding != 4'd0) outstanding_nx = outstanding - 4'd1;
        end
    end

    always_comb begin
        grant        = 2'b00;
        outbus.adr   = {AWIDTH{1'b0}};
        outbus.dat_w = {DWIDTH{1'b0}};
        outbus.sel   = {SWIDTH{1'b0}};
        outbus.we    = 1'b0;
        outbus.cyc   = 1'b0;
        outbus.stb   = 1'b0;
        in0.dat_r    = {DWIDTH{1'b0}};
        in0.ack      = 1'b0;
        in0.stall    = 1'b1;
        in1.dat_r    = {DWIDTH{1'b0}};
        in1.ack      = 1'b0;
        in1.stall    = 1'b1;
        unique case (state)
            S_GRANT0: begin
                grant        = 2'b01;
                outbus.adr   = in0.adr;
                outbus.dat_w = in0.dat_w;
                outbus.sel   = in0.sel;
                outbus.we    = in0.we;
                outbus.cyc   = in0.cyc;
                outbus.stb   = in0.stb;
                in0.dat_r    = outbus.dat_r;
                // An ack after the owner dropped cyc belongs to nobody
                in0.ack      = outbus.ack && in0.cyc;
                in0.stall    = outbus.stall;
            end
            S_GRANT1: begin
                grant        = 2'b10;
                outbus.adr   = in1.adr;
                outbus.dat_w = in1.dat_w;
                outbus.sel   = in1.sel;
                outbus.we    = in1.we;
                outbus.cyc   = in1.cyc;
                outbus.stb   = in1.stb;
                in1.dat_r    = outbus.dat_r;
                in1.ack      = outbus.ack && in1.cyc;
                in1.stall    = outbus.stall;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboard bench for wb_arbiter2: requester tasks push expected read
// data on each accepted beat; ack monitors pop and compare.
module tb_wb_arbiter2;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant;

    if_wb #(.AWIDTH(32), .DWIDTH(32)) b0 ();
    if_wb #(.AWIDTH(32), .DWIDTH(32)) b1 ();
    if_wb #(.AWIDTH(32), .DWIDTH(32)) bo ();

    wb_arbiter2 #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .in0   (b0),
        .in1   (b1),
        .outbus(bo),
        .grant (grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    // Slave model: one-cycle ack, data derived from address
    logic        s_ack     = 1'b0;
    logic        force_ack = 1'b0;
    logic        s_stall   = 1'b0;
    logic        slave_en  = 1'b1;
    logic [31:0] s_dat     = 32'h0;

    assign bo.ack   = s_ack | force_ack;
    assign bo.stall = s_stall;
    assign bo.dat_r = s_dat;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return 32'hA0 + {28'h0, a[5:2]};
    endfunction

    always @(posedge clk) begin
        s_ack <= slave_en & bo.cyc & bo.stb & ~bo.stall;
        s_dat <= rd_val(bo.adr);
    end

    // Scoreboard
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int ack0 = 0;
    int ack1 = 0;

    always @(negedge clk) begin
        if (b0.ack) begin
            if (exp0.size() == 0) check("ack0_unexpected", b0.ack, 1'b0);
            else check("ack0_dat", b0.dat_r, exp0.pop_front());
            ack0++;
        end
        if (b1.ack) begin
            if (exp1.size() == 0) check("ack1_unexpected", b1.ack, 1'b0);
            else check("ack1_dat", b1.dat_r, exp1.pop_front());
            ack1++;
        end
    end

    // Grant change log and no-owner quietness monitor
    int       g_val[$];
    int       g_cyc[$];
    int       cyc_n  = 0;
    int       viol   = 0;
    logic [1:0] g_prev = 2'b00;

    always @(negedge clk) begin
        cyc_n++;
        if (grant != g_prev) begin
            g_val.push_back(int'(grant));
            g_cyc.push_back(cyc_n);
        end
        g_prev = grant;
        if (grant == 2'b11) viol++;
        if (grant == 2'b00 && (bo.cyc || bo.stb || bo.we || bo.adr != 0
            || bo.dat_w != 0 || bo.sel != 0 || !b0.stall || !b1.stall
            || b0.ack || b1.ack || b0.dat_r != 0 || b1.dat_r != 0))
            viol++;
    end

    task automatic drive(input int p, input logic cyc, input logic stb,
                         input logic [31:0] adr, input logic we);
        if (p == 0) begin
            b0.cyc = cyc; b0.stb = stb; b0.adr = adr; b0.we = we;
            b0.dat_w = 32'hD000_0000 | adr; b0.sel = stb ? 4'hF : 4'h0;
        end else begin
            b1.cyc = cyc; b1.stb = stb; b1.adr = adr; b1.we = we;
            b1.dat_w = 32'hD000_0000 | adr; b1.sel = stb ? 4'hF : 4'h0;
        end
    endtask

    function automatic logic get_stall(input int p);
        return (p == 0) ? b0.stall : b1.stall;
    endfunction

    function automatic int get_acks(input int p);
        return (p == 0) ? ack0 : ack1;
    endfunction

    task automatic burst(input int p, input logic [31:0] base, input int n,
                         input logic we, input int hold);
        int beats = 0;
        int target;
        target = get_acks(p) + n;
        drive(p, 1'b1, 1'b1, base, we);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (beats < n && !get_stall(p)) begin
                if (p == 0) exp0.push_back(rd_val(base + 4 * beats));
                else exp1.push_back(rd_val(base + 4 * beats));
                beats++;
            end
            @(posedge clk); #1;
            if (beats < n) drive(p, 1'b1, 1'b1, base + 4 * beats, we);
            else drive(p, 1'b1, 1'b0, base + 4 * (n - 1), we);
            if (beats == n && get_acks(p) >= target) break;
        end
        check($sformatf("burst%0d_done", p),
              32'(beats == n && get_acks(p) >= target), 32'd1);
        repeat (hold) begin @(posedge clk); #1; end
        drive(p, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int a0;
        int tgt;
        int nz[$];
        drive(0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_cyc", bo.cyc, 1'b0);
        check("rst_stall0", b0.stall, 1'b1);
        check("rst_stall1", b1.stall, 1'b1);
        check("rst_ack0", b0.ack, 1'b0);
        check("rst_adr", bo.adr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Single requester 4-beat read
        g_val.delete(); g_cyc.delete();
        a0 = ack0;
        fork
            burst(0, 32'h100, 4, 1'b0, 0);
            begin
                @(negedge clk);
                check("arb_idle_grant", grant, 2'b00);
                check("arb_idle_stb", bo.stb, 1'b0);
                @(negedge clk);
                check("arb_grant0", grant, 2'b01);
                check("arb_stb_fwd", bo.stb, 1'b1);
                check("arb_adr", bo.adr, 32'h100);
                check("arb_in1_stall", b1.stall, 1'b1);
            end
        join
        idle(3);
        check("single_acks", ack0 - a0, 4);
        check("single_log_len", g_val.size(), 2);
        check("single_log0", g_val[0], 1);

        // Tie after reset: in0 first, then two no-owner cycles, then in1
        rst = 1'b1; idle(1); rst = 1'b0; idle(2);
        g_val.delete(); g_cyc.delete();
        fork
            burst(0, 32'h100, 2, 1'b0, 0);
            burst(1, 32'h110, 2, 1'b0, 0);
        join
        idle(3);
        check("tie_log_len", g_val.size(), 4);
        check("tie_first", g_val[0], 1);
        check("tie_gap_val", g_val[1], 0);
        check("tie_second", g_val[2], 2);
        check("tie_gap_len", g_cyc[2] - g_cyc[1], 2);

        // Round robin with back-to-back re-requests
        g_val.delete(); g_cyc.delete();
        fork
            begin
                burst(0, 32'h120, 4, 1'b1, 0);
                burst(0, 32'h130, 4, 1'b1, 0);
            end
            begin
                burst(1, 32'h140, 4, 1'b1, 0);
                burst(1, 32'h150, 4, 1'b1, 0);
            end
        join
        idle(3);
        foreach (g_val[i]) if (g_val[i] != 0) nz.push_back(g_val[i]);
        check("rr_len", nz.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), nz[i], (i % 2 == 0) ? 1 : 2);

        // Slave stall on beat 2 of an in1 write burst
        tgt = ack1 + 4;
        fork
            burst(1, 32'h200, 4, 1'b1, 1);
            begin
                for (int t = 0; t < 50; t++) begin
                    @(posedge clk); #2;
                    if (bo.stb && bo.adr == 32'h204) break;
                end
                s_stall = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in1", b1.stall, 1'b1);
                    check("stall_adr", bo.adr, 32'h204);
                    check("stall_dat", bo.dat_w, 32'hD000_0204);
                    @(posedge clk); #2;
                end
                s_stall = 1'b0;
                for (int t = 0; t < 50; t++) begin
                    if (ack1 >= tgt) break;
                    @(posedge clk); #2;
                end
                @(negedge clk);
                check("stall_outst", dut.outstanding, 4'd0);
                check("stall_held", grant, 2'b10);
            end
        join
        idle(3);

        // Late ack after owner drops cyc
        slave_en = 1'b0;
        drive(0, 1'b1, 1'b1, 32'h300, 1'b0);
        idle(1);
        @(negedge clk);
        check("late_grant", grant, 2'b01);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 1'b0);
        force_ack = 1'b1;
        @(negedge clk);
        check("late_ack0_a", b0.ack, 1'b0);
        check("late_ack1_a", b1.ack, 1'b0);
        check("late_cyc_a", bo.cyc, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("late_ack0_b", b0.ack, 1'b0);
        check("late_cyc_b", bo.cyc, 1'b0);
        check("late_rel_grant", grant, 2'b00);
        @(posedge clk); #1;
        force_ack = 1'b0;
        idle(2);

        // Reset mid-burst, in1 waiting: in0 still wins afterwards
        drive(0, 1'b1, 1'b1, 32'h100, 1'b0);
        idle(1);
        @(negedge clk);
        check("rmb_grant0", grant, 2'b01);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h104, 1'b0);
        drive(1, 1'b1, 1'b1, 32'h180, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        check("rmb_cyc", bo.cyc, 1'b0);
        check("rmb_grant", grant, 2'b00);
        check("rmb_ack0", b0.ack, 1'b0);
        check("rmb_stall0", b0.stall, 1'b1);
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk);
        check("rmb_rearb", grant, 2'b01);
        check("rmb_adr", bo.adr, 32'h104);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(4);
        slave_en = 1'b1;

        check("exp0_empty", exp0.size(), 0);
        check("exp1_empty", exp1.size(), 0);
        check("idle_quiet", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
